// File: rtl/adc081s101_emu.sv
// ADC081S101 serial ADC emulator: drives miso for a cs/sclk receiver
// from a holding register, a fixed value, a ramp or a 0x55/0xAA pattern.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   cs, sclk          link inputs from the receiver (asynchronous to clk)
//   miso, miso_oe     serial data out and its tri-state enable
//   mode              0 stream, 1 fixed, 2 ramp, 3 alternating
//   fixed_val         sample used in fixed mode
//   sample_in/valid   stream sample write port, sample_ready = holding empty
//   busy              frame in progress (cs seen low)
//   frame_done/abort  1-cycle pulses on complete / truncated frame
//   underrun(_cnt)    stream frame started with no fresh sample, saturating count
module adc081s101_emu #(
    parameter int DATA_WIDTH  = 8,
    parameter int LEAD_ZEROS  = 3,
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  sclk,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] fixed_val,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  underrun,
    output logic [7:0]            underrun_cnt
);

    localparam int IDX_W = $clog2(FRAME_BITS);
    localparam logic [IDX_W-1:0] DATA_LO  = IDX_W'(LEAD_ZEROS);
    localparam logic [IDX_W-1:0] DATA_HI  = IDX_W'(LEAD_ZEROS + DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);
    localparam logic [DATA_WIDTH-1:0] ALT_INIT = {(DATA_WIDTH/2){2'b01}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nx;

    // Synchronizers reset to the idle-high level of both lines so that
    // leaving reset never fakes an edge.
    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
    logic cs_d, sclk_d;
    logic cs_s, sclk_s;
    logic cs_fall, cs_rise, sclk_fall;

    logic [DATA_WIDTH-1:0] shreg, hold, last, ramp, alt, src;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            mode_q;
    logic                  hold_full;
    logic                  load, adv, finish, abort;
    logic                  take, under, wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // An sclk edge coinciding with the cs fall is ignored simply
    // because IDLE does not look at sclk.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        adv      = 1'b0;
        finish   = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else if (sclk_fall) begin
                    adv = 1'b1;
                    if (idx == LAST_IDX) begin
                        finish   = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_rise) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        take  = load && (mode == 2'd0) && hold_full;
        under = load && (mode == 2'd0) && !hold_full;
        case (mode)
            2'd0:    src = hold_full ? hold : last;
            2'd1:    src = fixed_val;
            2'd2:    src = ramp;
            default: src = alt;
        endcase
    end

    // A write can only land while the register is empty, so it never
    // collides with a consume; on an underrun start it simply refills.
    assign wr = sample_valid && !hold_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg        <= '0;
            hold         <= '0;
            hold_full    <= 1'b0;
            last         <= '0;
            ramp         <= '0;
            alt          <= ALT_INIT;
            idx          <= '0;
            mode_q       <= 2'd0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            frame_done  <= finish;
            frame_abort <= abort;
            underrun    <= under;
            if (wr) begin
                hold      <= sample_in;
                hold_full <= 1'b1;
            end else if (take) begin
                hold_full <= 1'b0;
            end
            if (take) last <= hold;
            if (under && underrun_cnt != 8'hFF)
                underrun_cnt <= underrun_cnt + 8'd1;
            if (load) begin
                shreg  <= src;
                idx    <= '0;
                mode_q <= mode;
            end else if (adv) begin
                idx <= idx + 1'b1;
                if (idx >= DATA_LO && idx < DATA_HI)
                    shreg <= shreg << 1;
            end
            if (finish) begin
                if (mode_q == 2'd2) ramp <= ramp + 1'b1;
                if (mode_q == 2'd3) alt  <= ~alt;
            end
        end
    end

    assign busy         = (state != IDLE);
    assign miso_oe      = (state != IDLE);
    assign sample_ready = !hold_full;
    assign miso         = (state == SHIFT) && (idx >= DATA_LO) &&
                          (idx < DATA_HI) && shreg[DATA_WIDTH-1];

endmodule
